// File: rtl/gray_to_binary_serial_if.sv
// Handshake bundle for the serial Gray-to-binary decoder.
// The master side feeds Gray words and consumes binary words; the slave side is the decoder.
interface gray_to_binary_serial_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             busy;

    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dout,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dout,
        output busy
    );
endinterface

// File: rtl/gray_to_binary_serial.sv
// Bit-serial Gray-to-binary decoder: takes one Gray word, resolves one bit per clock MSB first,
// then holds the binary result until the consumer takes it.
module gray_to_binary_serial #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    gray_to_binary_serial_if.slave bus
);
    localparam int              IDXW    = $clog2(WIDTH);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] g_reg_r;
    logic [WIDTH-1:0] g_reg_s;
    logic [WIDTH-1:0] b_reg_r;
    logic [WIDTH-1:0] b_reg_s;
    logic [IDXW-1:0]  idx_r;
    logic [IDXW-1:0]  idx_s;
    logic             upper_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    // Already-decoded bit one position above i; selected by compare so the index never leaves range.
    function automatic logic upper_bit(input logic [WIDTH-1:0] b, input logic [IDXW-1:0] i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < WIDTH - 1; k++) begin
            r = (i == IDXW'(k)) ? b[k+1] : r;
        end
        return r;
    endfunction

    // Next-state, index and datapath update
    always_comb begin
        state_s = state_r;
        g_reg_s = g_reg_r;
        b_reg_s = b_reg_r;
        idx_s   = idx_r;
        upper_s = (idx_r == IDX_MAX) ? 1'b0 : upper_bit(b_reg_r, idx_r);
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    g_reg_s = bus.din;
                    b_reg_s = {WIDTH{1'b0}};
                    idx_s   = IDX_MAX;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                b_reg_s[idx_r] = upper_s ^ g_reg_r[idx_r];
                if (idx_r == IDX_ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s = idx_r - IDX_ONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output-flag registers; flags follow the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            g_reg_r     <= {WIDTH{1'b0}};
            b_reg_r     <= {WIDTH{1'b0}};
            idx_r       <= IDX_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            g_reg_r     <= g_reg_s;
            b_reg_r     <= b_reg_s;
            idx_r       <= idx_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.dout      = b_reg_r;
endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Self-checking bench for gray_to_binary_serial at WIDTH=4 and WIDTH=8, compared against a
// prefix-XOR reference model and a binary-to-Gray encoder model.
module tb_gray_to_binary_serial;
    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    gray_to_binary_serial_if #(.WIDTH(4)) bus4 ();
    gray_to_binary_serial_if #(.WIDTH(8)) bus8 ();

    gray_to_binary_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    gray_to_binary_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word on the 4-bit DUT from IDLE and reports latency and result, then acknowledges.
    task automatic run_word4(input logic [3:0] g, output int lat, output logic [3:0] res,
                             output logic busy_ok);
        bus4.din = g;
        bus4.in_valid = 1'b1;
        bus4.out_ready = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (bus4.out_valid !== 1'b1 && lat < 40) begin
            if (bus4.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (bus4.busy !== 1'b1) busy_ok = 1'b0;
        res = bus4.dout;
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus4.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready); end
        tests_run++;
        if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        tests_run++;
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus4.busy); end
        tests_run++;
        if (bus4.dout !== 4'h0) begin tests_failed++; $display("FAIL reset_dout4: got %h want 0", bus4.dout); end
        tests_run++;
        if (bus8.dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout8: got %h want 00", bus8.dout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        logic [3:0] res;
        logic bok;
        run_word4(4'b0110, lat, res, bok);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL basic_latency: got %0d want 4", lat); end
        tests_run++;
        if (res !== 4'b0100) begin tests_failed++; $display("FAIL basic_dout: got %b want 0100", res); end
        tests_run++;
        if (bok !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b want 1", bok); end
    endtask

    task automatic test_known_vectors();
        int lat;
        logic [3:0] res;
        logic bok;
        run_word4(4'b1000, lat, res, bok);
        tests_run++;
        if (res !== 4'b1111) begin tests_failed++; $display("FAIL vec_1000: got %b want 1111", res); end
        // 8-bit instance: 8'hFF decodes to alternating bits
        bus8.din = 8'hFF;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat !== 8) begin tests_failed++; $display("FAIL w8_latency: got %0d want 8", lat); end
        tests_run++;
        if (bus8.dout !== 8'hAA) begin tests_failed++; $display("FAIL w8_dout: got %h want aa", bus8.dout); end
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            logic [7:0] g;
            g = 8'($urandom);
            bus8.din = g;
            bus8.in_valid = 1'b1;
            tick();
            bus8.in_valid = 1'b0;
            lat = 0;
            while (bus8.out_valid !== 1'b1 && lat < 40) begin
                tick();
                lat++;
            end
            tests_run++;
            if (bus8.dout !== 8'(gray2bin(32'(g)))) begin
                tests_failed++;
                $display("FAIL w8_random: din %h got %h want %h", g, bus8.dout, 8'(gray2bin(32'(g))));
            end
            bus8.out_ready = 1'b1;
            tick();
            bus8.out_ready = 1'b0;
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] expq[$];
        logic [3:0] exp_v;
        logic [3:0] dsamp;
        logic acc, ack;
        int v = 0;
        int outs = 0;
        int last_acc = -1;
        int cyc = 0;
        bus4.out_ready = 1'b1;
        bus4.din = 4'(bin2gray(32'd0));
        bus4.in_valid = 1'b1;
        while (outs < 16 && cyc < 300) begin
            acc = bus4.in_valid & bus4.in_ready;
            ack = bus4.out_valid & bus4.out_ready;
            dsamp = bus4.dout;
            tick();
            cyc++;
            if (ack) begin
                exp_v = (expq.size() > 0) ? expq.pop_front() : 4'hx;
                tests_run++;
                if (dsamp !== exp_v) begin tests_failed++; $display("FAIL exhaustive_dout: got %h want %h", dsamp, exp_v); end
                outs++;
            end
            if (acc) begin
                expq.push_back(4'(v));
                if (last_acc >= 0) begin
                    tests_run++;
                    if (cyc - last_acc !== 6) begin tests_failed++; $display("FAIL exhaustive_spacing: got %0d want 6", cyc - last_acc); end
                end
                last_acc = cyc;
                v++;
                if (v < 16) bus4.din = 4'(bin2gray(32'(v)));
                else bus4.in_valid = 1'b0;
            end
        end
        tests_run++;
        if (outs !== 16) begin tests_failed++; $display("FAIL exhaustive_count: got %0d want 16", outs); end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] g1, g2, r1;
        int lat;
        g1 = 4'($urandom);
        g2 = 4'($urandom);
        r1 = 4'(gray2bin(32'(g1)));
        bus4.out_ready = 1'b0;
        bus4.din = g1;
        bus4.in_valid = 1'b1;
        tick();
        bus4.din = g2;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (bus4.dout !== r1 || bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d dout %h ov %b ir %b want dout %h ov 1 ir 0",
                         k, bus4.dout, bus4.out_valid, bus4.in_ready, r1);
            end
            tick();
        end
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        tests_run++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: ir %b ov %b busy %b want 1 0 0", bus4.in_ready, bus4.out_valid, bus4.busy);
        end
        tick();
        bus4.in_valid = 1'b0;
        tests_run++;
        if (bus4.busy !== 1'b1) begin tests_failed++; $display("FAIL bp_accept: busy %b want 1", bus4.busy); end
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        tests_run++;
        if (bus4.dout !== 4'(gray2bin(32'(g2)))) begin
            tests_failed++;
            $display("FAIL bp_second: got %h want %h", bus4.dout, 4'(gray2bin(32'(g2))));
        end
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic stale;
        bus4.din = 4'b1011;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bus4.out_valid !== 1'b0 || bus4.dout !== 4'h0 || bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_state: ov %b dout %h ir %b busy %b want 0 0 1 0",
                     bus4.out_valid, bus4.dout, bus4.in_ready, bus4.busy);
        end
        stale = 1'b0;
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (bus4.out_valid !== 1'b0) stale = 1'b1;
            tick();
        end
        bus4.out_ready = 1'b0;
        tests_run++;
        if (stale !== 1'b0) begin tests_failed++; $display("FAIL midreset_stale: out_valid seen %b want 0", stale); end
    endtask

    task automatic test_random();
        logic [3:0] expq[$];
        logic [3:0] exp_v;
        logic [3:0] dsamp;
        logic acc, ack;
        int sent = 0;
        int outs = 0;
        int cyc = 0;
        while (outs < 30 && cyc < 3000) begin
            bus4.in_valid = (sent < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus4.din = 4'($urandom);
            bus4.out_ready = 1'($urandom_range(0, 1));
            #1;
            tests_run++;
            if (bus4.busy !== ~bus4.in_ready) begin
                tests_failed++;
                $display("FAIL random_flags: busy %b in_ready %b", bus4.busy, bus4.in_ready);
            end
            acc = bus4.in_valid & bus4.in_ready;
            ack = bus4.out_valid & bus4.out_ready;
            dsamp = bus4.dout;
            if (acc) begin
                expq.push_back(4'(gray2bin(32'(bus4.din))));
                sent++;
            end
            tick();
            cyc++;
            if (ack) begin
                exp_v = (expq.size() > 0) ? expq.pop_front() : 4'hx;
                tests_run++;
                if (dsamp !== exp_v) begin tests_failed++; $display("FAIL random_dout: got %h want %h", dsamp, exp_v); end
                outs++;
            end
        end
        tests_run++;
        if (outs !== 30) begin tests_failed++; $display("FAIL random_count: got %0d want 30", outs); end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.din = 4'h0;
        bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.din = 8'h00;
        bus8.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_known_vectors();
        test_exhaustive();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
